// File: rtl/sopc_system_linux_cpu_jtag_debug_host.sv
`default_nettype none
// ============================================================================
// Module      : sopc_system_linux_cpu_jtag_debug_host
// Description : Host-side virtual-JTAG driver for the CPU debug module. It runs
//               UIR->CDR->SDR->UDR->RTI on a divided TCK and returns the DR.
// Revision    : 1.0 - initial release
// ============================================================================
module sopc_system_linux_cpu_jtag_debug_host #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_uir  = 3'd1;
  localparam logic [2:0] c_st_cdr  = 3'd2;
  localparam logic [2:0] c_st_sdr  = 3'd3;
  localparam logic [2:0] c_st_udr  = 3'd4;
  localparam logic [2:0] c_st_rti  = 3'd5;
  localparam logic [2:0] c_st_resp = 3'd6;

  localparam int               c_bw       = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [c_bw-1:0]  c_bit_last = c_bw'(DR_WIDTH - 1);
  localparam logic [c_bw-1:0]  c_bit_one  = c_bw'(1);
  localparam logic [7:0]       c_div_last = 8'(TCK_DIV - 1);

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic [7:0]          r_div_cnt;
  logic                r_tck;
  logic [c_bw-1:0]     r_bit_cnt;
  logic [DR_WIDTH-1:0] r_shift;
  logic                r_tdi;
  logic [IR_WIDTH-1:0] r_ir_in;
  logic [IR_WIDTH-1:0] r_ir_cap;
  logic [DR_WIDTH-1:0] r_rsp_data;
  logic [IR_WIDTH-1:0] r_rsp_ir;

  logic w_run;
  logic w_term;
  logic w_rise;
  logic w_fall;
  logic w_last_bit;

  // TCK only runs while a TAP state is active; every state ends on a falling edge.
  assign w_run      = (r_state >= c_st_uir) && (r_state <= c_st_rti);
  assign w_term     = (r_div_cnt == c_div_last);
  assign w_rise     = w_run && w_term && !r_tck;
  assign w_fall     = w_run && w_term && r_tck;
  assign w_last_bit = (r_bit_cnt == c_bit_last);

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (cmd_valid) w_state_next = c_st_uir;
      c_st_uir:  if (w_fall) w_state_next = c_st_cdr;
      c_st_cdr:  if (w_fall) w_state_next = c_st_sdr;
      c_st_sdr:  if (w_fall && w_last_bit) w_state_next = c_st_udr;
      c_st_udr:  if (w_fall) w_state_next = c_st_rti;
      c_st_rti:  if (w_fall) w_state_next = c_st_resp;
      c_st_resp: w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    vji_uir   = 1'b0;
    vji_cdr   = 1'b0;
    vji_sdr   = 1'b0;
    vji_udr   = 1'b0;
    vji_rti   = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      c_st_uir:  vji_uir   = 1'b1;
      c_st_cdr:  vji_cdr   = 1'b1;
      c_st_sdr:  vji_sdr   = 1'b1;
      c_st_udr:  vji_udr   = 1'b1;
      c_st_rti:  vji_rti   = 1'b1;
      c_st_resp: rsp_valid = 1'b1;
      default:   ;
    endcase
    cmd_ready = (r_state == c_st_idle) && !reset;
    busy      = (r_state != c_st_idle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_tck      <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tdi      <= 1'b0;
      r_ir_in    <= '0;
      r_ir_cap   <= '0;
      r_rsp_data <= '0;
      r_rsp_ir   <= '0;
    end else begin
      if (w_run) begin
        if (w_term) begin
          r_div_cnt <= '0;
          r_tck     <= ~r_tck;
        end else begin
          r_div_cnt <= r_div_cnt + 8'd1;
        end
      end else begin
        r_div_cnt <= '0;
        r_tck     <= 1'b0;
      end
      if (r_state == c_st_idle && cmd_valid) begin
        r_ir_in   <= cmd_ir;
        r_shift   <= cmd_data;
        r_bit_cnt <= '0;
      end
      if (r_state == c_st_uir && w_rise) r_ir_cap <= vji_ir_out;
      if (r_state == c_st_cdr && w_fall) r_tdi <= r_shift[0];
      if (r_state == c_st_sdr && w_rise) r_shift <= {vji_tdo, r_shift[DR_WIDTH-1:1]};
      // tdi leads each low half with the bit that the coming rising edge captures.
      if (r_state == c_st_sdr && w_fall) begin
        if (w_last_bit) begin
          r_tdi <= 1'b0;
        end else begin
          r_tdi     <= r_shift[0];
          r_bit_cnt <= r_bit_cnt + c_bit_one;
        end
      end
      if (r_state == c_st_rti && w_fall) begin
        r_rsp_data <= r_shift;
        r_rsp_ir   <= r_ir_cap;
      end
    end
  end

  assign vji_tck    = r_tck;
  assign vji_tdi    = r_tdi;
  assign vji_ir_in  = r_ir_in;
  assign rsp_data   = r_rsp_data;
  assign rsp_ir_out = r_rsp_ir;

endmodule
`default_nettype wire
